// File: rtl/ah_mul_pkg.sv
// Shared configuration, stage bundle and helpers for the pipelined signed multiplier.
package ah_mul_pkg;

    // Configuration point for the whole multiplier; the stage bundle is sized from these.
    localparam int DEF_WIDTH  = 32;
    localparam int DEF_STAGES = 8;

    localparam int P_BITS  = DEF_WIDTH / DEF_STAGES;  // multiplier bits consumed per stage
    localparam int LATENCY = DEF_STAGES + 2;          // input reg + accumulate stages + output reg

    // Everything one accumulate stage hands to the next.
    typedef struct packed {
        logic                     valid;
        logic                     neg;
        logic                     zero;
        logic [DEF_WIDTH-1:0]     abs_a;
        logic [DEF_WIDTH-1:0]     abs_b;
        logic [2*DEF_WIDTH-1:0]   acc;
    } stage_t;

    // Magnitude of a two's-complement value; the most negative value maps onto 2^(W-1).
    function automatic logic [DEF_WIDTH-1:0] abs_val(input logic [DEF_WIDTH-1:0] v);
        return v[DEF_WIDTH-1] ? -v : v;
    endfunction

endpackage

// File: rtl/ah_mul_stage.sv
// One shift-and-add stage: folds a P_BITS slice of |B| times |A| into the accumulator.
module ah_mul_stage
    import ah_mul_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int P_BITS = 4,
    parameter int INDEX  = 1
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    input  stage_t stage_i,
    output stage_t stage_o
);

    stage_t             stage_d, stage_q;
    logic [2*WIDTH-1:0] a_ext, slice_ext, partial;

    // Partial product for this slice, shifted into place and added to the running sum.
    always_comb begin
        // NOTE: stage_d takes a full default before any field is overridden, so no path leaves it unassigned and no latch is inferred.
        stage_d   = stage_i;
        a_ext     = {{WIDTH{1'b0}}, stage_i.abs_a};
        slice_ext = {{(2*WIDTH-P_BITS){1'b0}}, stage_i.abs_b[INDEX*P_BITS-1 -: P_BITS]};
        partial   = (a_ext * slice_ext) << ((INDEX-1)*P_BITS);
        stage_d.acc = stage_i.acc + partial;
    end

    // Stage register: cleared by reset, frozen while en is low.
    always_ff @(posedge clk) begin
        // NOTE: rst is tested ahead of en so a reset during a hold still empties the pipe.
        if (rst) begin
            // NOTE: non-blocking assignment so every stage samples its neighbour's pre-edge value.
            stage_q <= '0;
        end else if (en) begin
            stage_q <= stage_d;
        end
    end

    assign stage_o = stage_q;

endmodule

// File: rtl/ah_mul_pipelined.sv
// Fully pipelined signed multiplier: sign-magnitude shift-and-add with a global hold.
module ah_mul_pipelined
    import ah_mul_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      start,
    input  logic signed [WIDTH-1:0]   multiplicand,
    input  logic signed [WIDTH-1:0]   multiplier,
    output logic signed [2*WIDTH-1:0] product,
    output logic                      data_valid,
    output logic                      zero_operand,
    output logic                      overflow
);

    // Parameter legality: the multiplier must split evenly into stages, and the
    // stage bundle in ah_mul_pkg must be sized for this configuration.
    generate
        if (WIDTH % STAGES != 0) begin : g_bad_split
            $error("ah_mul_pipelined: WIDTH (%0d) must be a multiple of STAGES (%0d)", WIDTH, STAGES);
        end
        if (WIDTH < 4) begin : g_bad_width
            $error("ah_mul_pipelined: WIDTH (%0d) must be at least 4", WIDTH);
        end
        if (WIDTH != DEF_WIDTH || STAGES != DEF_STAGES) begin : g_bad_pkg
            $error("ah_mul_pipelined: WIDTH/STAGES must match DEF_WIDTH/DEF_STAGES in ah_mul_pkg");
        end
    endgenerate

    localparam int SLICE = WIDTH / STAGES;

    stage_t in_d, in_q;
    stage_t pipe [0:STAGES];

    // Input stage: strip signs, remember the result sign and the zero-operand case.
    always_comb begin
        in_d       = '0;
        in_d.valid = start;
        in_d.neg   = multiplicand[WIDTH-1] ^ multiplier[WIDTH-1];
        in_d.zero  = (multiplicand == '0) || (multiplier == '0);
        in_d.abs_a = abs_val(multiplicand);
        in_d.abs_b = abs_val(multiplier);
    end

    // Input register.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_q <= '0;
        end else if (en) begin
            in_q <= in_d;
        end
    end

    assign pipe[0] = in_q;

    // Accumulate stages, least significant multiplier slice first.
    generate
        for (genvar g = 1; g <= STAGES; g++) begin : g_stage
            ah_mul_stage #(
                .WIDTH  (WIDTH),
                .P_BITS (SLICE),
                .INDEX  (g)
            ) u_stage (
                .clk     (clk),
                .rst     (rst),
                .en      (en),
                .stage_i (pipe[g-1]),
                .stage_o (pipe[g])
            );
        end
    endgenerate

    stage_t             last;
    logic [2*WIDTH-1:0] product_d, product_q;
    logic               data_valid_d, data_valid_q;
    logic               zero_operand_d, zero_operand_q;
    logic               overflow_d, overflow_q;
    logic [WIDTH:0]     top_bits;
    logic               unused_magnitudes;

    assign last              = pipe[STAGES];
    assign unused_magnitudes = ^{last.abs_a, last.abs_b};

    // Output stage: reapply the sign (never for a zero operand) and flag results
    // that do not fit in WIDTH signed bits; flags are qualified by valid.
    always_comb begin
        product_d      = (last.neg && !last.zero) ? -last.acc : last.acc;
        top_bits       = product_d[2*WIDTH-1:WIDTH-1];
        data_valid_d   = last.valid;
        zero_operand_d = last.valid && last.zero;
        overflow_d     = last.valid && (top_bits != '0) && (top_bits != '1);
    end

    // Output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            product_q      <= '0;
            data_valid_q   <= 1'b0;
            zero_operand_q <= 1'b0;
            overflow_q     <= 1'b0;
        end else if (en) begin
            product_q      <= product_d;
            data_valid_q   <= data_valid_d;
            zero_operand_q <= zero_operand_d;
            overflow_q     <= overflow_d;
        end
    end

    assign product      = product_q;
    assign data_valid   = data_valid_q;
    assign zero_operand = zero_operand_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_ah_mul_pipelined.sv
// Directed bench for ah_mul_pipelined: latency, exact products, flags, hold and reset.
module tb_ah_mul_pipelined;
    import ah_mul_pkg::LATENCY;

    logic               clk;
    logic               rst;
    logic               en;
    logic               start;
    logic signed [31:0] a;
    logic signed [31:0] b;
    logic signed [63:0] product;
    logic               data_valid;
    logic               zero_operand;
    logic               overflow;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;

    // Stimulus / expectation tables shared by the stream scenarios.
    logic signed [31:0] va [16];
    logic signed [31:0] vb [16];
    logic signed [63:0] ep [16];
    logic               eo [16];
    logic               ez [16];

    ah_mul_pipelined #(.WIDTH(32), .STAGES(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .start        (start),
        .multiplicand (a),
        .multiplier   (b),
        .product      (product),
        .data_valid   (data_valid),
        .zero_operand (zero_operand),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_op(input int i, input logic signed [31:0] ai, input logic signed [31:0] bi,
                          input logic signed [63:0] pi, input logic oi, input logic zi);
        va[i] = ai; vb[i] = bi; ep[i] = pi; eo[i] = oi; ez[i] = zi;
    endtask

    task automatic idle_inputs();
        start = 1'b0; a = '0; b = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; start = 1'b1; a = 32'sd9; b = 32'sd9;
        step(); step();
        rst = 1'b0; idle_inputs();
        total_cnt++; if (product !== 64'sd0) $display("FAIL reset_product: got %0d want 0", product); else pass_cnt++;
        total_cnt++; if (data_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", data_valid); else pass_cnt++;
        total_cnt++; if (zero_operand !== 1'b0) $display("FAIL reset_zero: got %b want 0", zero_operand); else pass_cnt++;
        total_cnt++; if (overflow !== 1'b0) $display("FAIL reset_ovf: got %b want 0", overflow); else pass_cnt++;
    endtask

    task automatic test_single();
        int t0, n, first;
        logic signed [63:0] p;
        logic z, o;
        t0 = cyc; n = 0; first = -1; p = '0; z = 1'b0; o = 1'b0;
        en = 1'b1; start = 1'b1; a = 32'sd7; b = -32'sd3;
        step();
        idle_inputs();
        while (cyc < t0 + LATENCY + 6) begin
            if (data_valid === 1'b1) begin
                n++;
                if (first < 0) begin first = cyc; p = product; z = zero_operand; o = overflow; end
            end
            step();
        end
        total_cnt++; if (n != 1) $display("FAIL single_pulses: got %0d want 1", n); else pass_cnt++;
        total_cnt++; if (first != t0 + LATENCY) $display("FAIL single_latency: got %0d want %0d", first - t0, LATENCY); else pass_cnt++;
        total_cnt++; if (p !== -64'sd21) $display("FAIL single_product: got %0d want -21", p); else pass_cnt++;
        total_cnt++; if (z !== 1'b0) $display("FAIL single_zero: got %b want 0", z); else pass_cnt++;
        total_cnt++; if (o !== 1'b0) $display("FAIL single_ovf: got %b want 0", o); else pass_cnt++;
    endtask

    task automatic test_extremes();
        int t0, k;
        set_op(0, 32'h8000_0000, 32'h8000_0000, 64'sh4000_0000_0000_0000, 1'b1, 1'b0);
        set_op(1, 32'h8000_0000, 32'sd1,        64'shFFFF_FFFF_8000_0000, 1'b0, 1'b0);
        t0 = cyc; k = 0; en = 1'b1;
        for (int c = 0; c < 2 + LATENCY + 4; c++) begin
            if (c < 2) begin start = 1'b1; a = va[c]; b = vb[c]; end else idle_inputs();
            step();
            if (data_valid === 1'b1) begin
                total_cnt++;
                if (k >= 2 || cyc != t0 + LATENCY + k || product !== ep[k] || overflow !== eo[k] || zero_operand !== ez[k])
                    $display("FAIL extreme[%0d]: cyc=%0d product=%h ovf=%b zero=%b want cyc=%0d product=%h ovf=%b zero=%b",
                             k, cyc - t0, product, overflow, zero_operand, LATENCY + k, ep[k], eo[k], ez[k]);
                else pass_cnt++;
                k++;
            end
        end
        total_cnt++; if (k != 2) $display("FAIL extreme_count: got %0d want 2", k); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int t0, k;
        set_op(0,  32'sd1,        32'sd1,        64'sd1,                    1'b0, 1'b0);
        set_op(1,  -32'sd1,       -32'sd1,       64'sd1,                    1'b0, 1'b0);
        set_op(2,  -32'sd1,       32'sd1,        -64'sd1,                   1'b0, 1'b0);
        set_op(3,  32'sd2,        32'sd3,        64'sd6,                    1'b0, 1'b0);
        set_op(4,  32'sd100,      -32'sd100,     -64'sd10000,               1'b0, 1'b0);
        set_op(5,  -32'sd7,       32'sd8,        -64'sd56,                  1'b0, 1'b0);
        set_op(6,  32'sd65536,    32'sd65536,    64'sh0000_0001_0000_0000,  1'b1, 1'b0);
        set_op(7,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'sh3FFF_FFFF_0000_0001,  1'b1, 1'b0);
        set_op(8,  32'h8000_0000, 32'h7FFF_FFFF, 64'shC000_0000_8000_0000,  1'b1, 1'b0);
        set_op(9,  32'sd12345,    -32'sd6789,    -64'sd83810205,            1'b0, 1'b0);
        set_op(10, 32'sd32767,    32'sd32767,    64'sd1073676289,           1'b0, 1'b0);
        set_op(11, 32'sd46341,    32'sd46341,    64'sh0000_0000_8000_1219,  1'b1, 1'b0);
        set_op(12, -32'sd46341,   32'sd46341,    64'shFFFF_FFFF_7FFF_EDE7,  1'b1, 1'b0);
        set_op(13, -32'sd65536,   32'sd32768,    64'shFFFF_FFFF_8000_0000,  1'b0, 1'b0);
        set_op(14, 32'sd3,        -32'sd5,       -64'sd15,                  1'b0, 1'b0);
        set_op(15, 32'h8000_0000, -32'sd1,       64'sh0000_0000_8000_0000,  1'b1, 1'b0);
        t0 = cyc; k = 0; en = 1'b1;
        for (int c = 0; c < 16 + LATENCY + 4; c++) begin
            if (c < 16) begin start = 1'b1; a = va[c]; b = vb[c]; end else idle_inputs();
            step();
            if (data_valid === 1'b1) begin
                total_cnt++;
                if (k >= 16 || cyc != t0 + LATENCY + k || product !== ep[k] || overflow !== eo[k] || zero_operand !== ez[k])
                    $display("FAIL b2b[%0d]: cyc=%0d product=%0d ovf=%b zero=%b want cyc=%0d product=%0d ovf=%b zero=%b",
                             k, cyc - t0, product, overflow, zero_operand, LATENCY + k, ep[k], eo[k], ez[k]);
                else pass_cnt++;
                k++;
            end
        end
        total_cnt++; if (k != 16) $display("FAIL b2b_count: got %0d want 16", k); else pass_cnt++;
    endtask

    task automatic test_zero();
        int t0, k;
        set_op(0, 32'sd0,      -32'sd5, 64'sd0, 1'b0, 1'b1);
        set_op(1, 32'sd123456, 32'sd0,  64'sd0, 1'b0, 1'b1);
        t0 = cyc; k = 0; en = 1'b1;
        for (int c = 0; c < 2 + LATENCY + 4; c++) begin
            if (c < 2) begin start = 1'b1; a = va[c]; b = vb[c]; end else idle_inputs();
            step();
            if (data_valid === 1'b1) begin
                total_cnt++;
                if (k >= 2 || cyc != t0 + LATENCY + k || product !== ep[k] || overflow !== eo[k] || zero_operand !== ez[k])
                    $display("FAIL zero[%0d]: cyc=%0d product=%0d ovf=%b zero=%b want cyc=%0d product=%0d ovf=%b zero=%b",
                             k, cyc - t0, product, overflow, zero_operand, LATENCY + k, ep[k], eo[k], ez[k]);
                else pass_cnt++;
                k++;
            end
        end
        total_cnt++; if (k != 2) $display("FAIL zero_count: got %0d want 2", k); else pass_cnt++;
    endtask

    // Three ops, then en low for five edges starting at relative cycle 4.
    task automatic test_hold();
        int t0, k;
        logic hold;
        logic signed [63:0] snap_p;
        logic snap_v;
        set_op(0, 32'sd11,   32'sd13,    64'sd143,      1'b0, 1'b0);
        set_op(1, -32'sd9,   32'sd9,     -64'sd81,      1'b0, 1'b0);
        set_op(2, 32'sd1000, -32'sd1000, -64'sd1000000, 1'b0, 1'b0);
        t0 = cyc; k = 0; snap_p = '0; snap_v = 1'b0;
        for (int c = 0; c < 30; c++) begin
            hold = (c >= 4) && (c <= 8);
            en = !hold;
            if (c < 3) begin start = 1'b1; a = va[c]; b = vb[c]; end
            else if (hold) begin start = 1'b1; a = 32'sd77; b = 32'sd77; end
            else idle_inputs();
            if (c == 4) begin snap_p = product; snap_v = data_valid; end
            step();
            if (hold) begin
                total_cnt++;
                if (product !== snap_p || data_valid !== snap_v)
                    $display("FAIL hold_frozen[%0d]: product=%0d valid=%b want product=%0d valid=%b", c, product, data_valid, snap_p, snap_v);
                else pass_cnt++;
            end else if (data_valid === 1'b1) begin
                total_cnt++;
                if (k >= 3 || cyc != t0 + LATENCY + 5 + k || product !== ep[k])
                    $display("FAIL hold_result[%0d]: cyc=%0d product=%0d want cyc=%0d product=%0d", k, cyc - t0, product, LATENCY + 5 + k, ep[k]);
                else pass_cnt++;
                k++;
            end
        end
        en = 1'b1;
        total_cnt++; if (k != 3) $display("FAIL hold_count: got %0d want 3", k); else pass_cnt++;
    endtask

    // A valid result must stay on the outputs, unchanged, while en is low.
    task automatic test_hold_output();
        int t0;
        t0 = cyc; en = 1'b1; start = 1'b1; a = 32'sd5; b = 32'sd5;
        step();
        idle_inputs();
        while (cyc < t0 + LATENCY) step();
        total_cnt++;
        if (data_valid !== 1'b1 || product !== 64'sd25)
            $display("FAIL holdout_first: valid=%b product=%0d want valid=1 product=25", data_valid, product);
        else pass_cnt++;
        en = 1'b0; start = 1'b1; a = -32'sd1; b = -32'sd1;
        for (int i = 0; i < 3; i++) begin
            step();
            total_cnt++;
            if (data_valid !== 1'b1 || product !== 64'sd25 || zero_operand !== 1'b0)
                $display("FAIL holdout_kept[%0d]: valid=%b product=%0d zero=%b want valid=1 product=25 zero=0", i, data_valid, product, zero_operand);
            else pass_cnt++;
        end
        en = 1'b1; idle_inputs();
        step();
        total_cnt++; if (data_valid !== 1'b0) $display("FAIL holdout_release: valid=%b want 0", data_valid); else pass_cnt++;
    endtask

    // Four ops in flight, one-cycle reset at relative cycle 6, then a fresh op.
    task automatic test_reset_midflight();
        int t0, t1, n, first;
        logic signed [63:0] p;
        t0 = cyc; n = 0; en = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            if (c < 4) begin start = 1'b1; a = 32'(c + 1); b = 32'sd3; end else idle_inputs();
            rst = (c == 6);
            step();
            if (data_valid === 1'b1) n++;
        end
        rst = 1'b0;
        total_cnt++;
        if (product !== 64'sd0 || data_valid !== 1'b0)
            $display("FAIL midreset_clear: product=%0d valid=%b want product=0 valid=0", product, data_valid);
        else pass_cnt++;
        for (int i = 0; i < 20; i++) begin
            step();
            if (data_valid === 1'b1) n++;
        end
        total_cnt++; if (n != 0) $display("FAIL midreset_flushed: got %0d pulses want 0", n); else pass_cnt++;
        t1 = cyc; n = 0; first = -1; p = '0;
        start = 1'b1; a = 32'sd6; b = -32'sd7;
        step();
        idle_inputs();
        while (cyc < t1 + LATENCY + 4) begin
            if (data_valid === 1'b1) begin
                n++;
                if (first < 0) begin first = cyc; p = product; end
            end
            step();
        end
        total_cnt++; if (n != 1) $display("FAIL midreset_fresh_pulses: got %0d want 1", n); else pass_cnt++;
        total_cnt++; if (first != t1 + LATENCY) $display("FAIL midreset_fresh_latency: got %0d want %0d", first - t1, LATENCY); else pass_cnt++;
        total_cnt++; if (p !== -64'sd42) $display("FAIL midreset_fresh_product: got %0d want -42", p); else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; start = 1'b0; a = '0; b = '0;
        test_reset();
        test_single();
        test_extremes();
        test_back_to_back();
        test_zero();
        test_hold();
        test_hold_output();
        test_reset_midflight();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
